// File: rtl/shift_seq_32.sv
// rtl/shift_seq_32.sv - load-then-shift sequencer for a 32-bit 74LS194-style universal shift register
//
// Accepts a word, direction, shift mode and amount, parallel-loads the word into
// the external register, then issues exactly `amount` single-bit shifts. Fill bits
// for arithmetic/rotate modes come from the register's Q fed back on `q`.
//
// Optional feature macro: SHIFT_SEQ_ABORT_EN (adds `abort` input).
//
// Ports:
//   clk     in   1  rising-edge clock, shared with the shift register
//   clear   in   1  asynchronous active-low reset
//   start   in   1  operation request, sampled only in IDLE
//   din     in  32  word to shift
//   dir     in   1  0 = left (toward bit 31), 1 = right (toward bit 0)
//   mode    in   2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//   amount  in   5  shift count 0..31
//   q       in  32  register Q feedback
//   abort   in   1  (SHIFT_SEQ_ABORT_EN only) cancel in LOAD/SHIFT
//   pdata   out 32  register parallel data (latched word)
//   s       out  2  register mode select: 00 hold, 01 right, 10 left, 11 load
//   sr      out  1  serial-in at bit 31 for right shifts
//   sl      out  1  serial-in at bit 0 for left shifts
//   busy    out  1  high in LOAD, SHIFT, DONE
//   done    out  1  one-cycle completion pulse
//   result  out 32  final word, held until the next completion

module shift_seq_32 (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] din,
    input  logic        dir,
    input  logic [1:0]  mode,
    input  logic [4:0]  amount,
    input  logic [31:0] q,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic [31:0] pdata,
    output logic [1:0]  s,
    output logic        sr,
    output logic        sl,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    localparam logic [1:0] MODE_ARITH  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] word_l;
    logic        dir_l;
    logic [1:0]  mode_l;
    logic [4:0]  amt_l;
    logic        abort_req;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // The register only consumes pdata while s=11, so the latched word can be
    // presented continuously.
    assign pdata = word_l;

    // s, busy and done are registered alongside the state so they change only
    // on clock edges; start never reaches them combinationally.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state  <= ST_IDLE;
            cnt    <= 5'd0;
            word_l <= 32'd0;
            dir_l  <= 1'b0;
            mode_l <= 2'b00;
            amt_l  <= 5'd0;
            s      <= S_HOLD;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        word_l <= din;
                        dir_l  <= dir;
                        mode_l <= mode;
                        amt_l  <= amount;
                        state  <= ST_LOAD;
                        s      <= S_LOAD;
                        busy   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort_req) begin
                        state <= ST_IDLE;
                        s     <= S_HOLD;
                        busy  <= 1'b0;
                    end else if (amt_l == 5'd0) begin
                        state <= ST_DONE;
                        s     <= S_HOLD;
                        done  <= 1'b1;
                    end else begin
                        cnt   <= amt_l;
                        state <= ST_SHIFT;
                        s     <= dir_l ? S_RIGHT : S_LEFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort_req) begin
                        state <= ST_IDLE;
                        cnt   <= 5'd0;
                        s     <= S_HOLD;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 5'd1;
                        // The edge that ends this cycle performs the last shift.
                        if (cnt == 5'd1) begin
                            state <= ST_DONE;
                            s     <= S_HOLD;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    result <= q;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    s     <= S_HOLD;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Serial fill is taken live from the register so arithmetic replicates the
    // current sign bit and rotate recirculates the bit shifted out.
    always_comb begin
        sr = 1'b0;
        sl = 1'b0;
        if (state == ST_SHIFT) begin
            if (dir_l) begin
                if (mode_l == MODE_ARITH)
                    sr = q[31];
                else if (mode_l == MODE_ROTATE)
                    sr = q[0];
            end else begin
                if (mode_l == MODE_ROTATE)
                    sl = q[31];
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_32.sv
// tb/tb_shift_seq_32.sv - self-checking bench for shift_seq_32 driving a 32-bit universal shift register
module tb_shift_seq_32;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] din;
    logic        dir;
    logic [1:0]  mode;
    logic [4:0]  amount;
    logic [31:0] q;
    logic        abort;
    logic [31:0] pdata;
    logic [1:0]  s;
    logic        sr;
    logic        sl;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    shift_seq_32 dut (
        .clk    (clk),
        .clear  (clear),
        .start  (start),
        .din    (din),
        .dir    (dir),
        .mode   (mode),
        .amount (amount),
        .q      (q),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort  (abort),
`endif
        .pdata  (pdata),
        .s      (s),
        .sr     (sr),
        .sl     (sl),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Eight chained 4-bit universal slices behave as one 32-bit register.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            q <= 32'd0;
        else begin
            case (s)
                2'b01:   q <= {sr, q[31:1]};
                2'b10:   q <= {q[30:0], sl};
                2'b11:   q <= pdata;
                default: q <= q;
            endcase
        end
    end

    function automatic logic [31:0] ref_shift(input logic [31:0] w, input logic d,
                                              input logic [1:0] m, input int n);
        logic [63:0] dd;
        logic [63:0] t;
        logic [31:0] r;
        dd = {w, w};
        if (m == 2'b10) begin
            if (d) begin
                t = dd >> n;
                r = t[31:0];
            end else begin
                t = dd << n;
                r = t[63:32];
            end
        end else if (m == 2'b01) begin
            if (d) r = $unsigned($signed(w) >>> n);
            else   r = w << n;
        end else begin
            if (d) r = w >> n;
            else   r = w << n;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation; optionally pulses start with a different word mid-SHIFT.
    task automatic run_op(input string tag, input logic [31:0] w, input logic d,
                          input logic [1:0] m, input logic [4:0] n, input bit pulse_mid);
        logic [31:0] exp;
        int lat;
        int shift_cycles;
        exp = ref_shift(w, d, m, int'(n));
        @(negedge clk);
        din = w; dir = d; mode = m; amount = n; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din = $urandom; dir = 1'($urandom); mode = 2'($urandom); amount = 5'($urandom);
        lat = 0;
        shift_cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, " load_s"}, 32'(s), 32'(2'b11));
            if (pulse_mid && k == 3) begin
                start = 1'b1;
                din = ~w;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (s == (d ? 2'b01 : 2'b10)) shift_cycles++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(int'(n) + 2));
        check({tag, " shift_cycles"}, 32'(shift_cycles), 32'(n));
        @(posedge clk);
        @(negedge clk);
        check({tag, " result"}, result, exp);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        int t1;
        int t2;
        int cyc;
        int ndone;
        clear = 1'b0; start = 1'b0; abort = 1'b0;
        din = 32'hdeadbeef; dir = 1'b1; mode = 2'b01; amount = 5'd7;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst s", 32'(s), 32'd0);
        check("rst result", result, 32'd0);
        check("rst pdata", pdata, 32'd0);
        check("rst srsl", 32'({sr, sl}), 32'd0);
        clear = 1'b1;

        run_op("lsr4", 32'h80000001, 1'b1, 2'b00, 5'd4, 1'b0);
        check("lsr4 const", result, 32'h08000000);
        run_op("asr3", 32'h80000000, 1'b1, 2'b01, 5'd3, 1'b0);
        check("asr3 const", result, 32'hF0000000);
        run_op("asl1", 32'h40000001, 1'b0, 2'b01, 5'd1, 1'b0);
        check("asl1 const", result, 32'h80000002);
        run_op("rol1", 32'h80000001, 1'b0, 2'b10, 5'd1, 1'b0);
        check("rol1 const", result, 32'h00000003);
        run_op("ror31", 32'h00000001, 1'b1, 2'b10, 5'd31, 1'b0);
        check("ror31 const", result, 32'h00000002);
        run_op("amt0", 32'h12345678, 1'b0, 2'b00, 5'd0, 1'b0);
        check("amt0 const", result, 32'h12345678);
        run_op("busy_start", 32'hA5A5F00F, 1'b1, 2'b01, 5'd6, 1'b1);
        run_op("reserved", 32'hF000000F, 1'b1, 2'b11, 5'd2, 1'b0);

        for (int i = 0; i < 20; i++)
            run_op("rand", $urandom, 1'($urandom), 2'($urandom), 5'($urandom), 1'b0);

        // start held high: accepted again on the first IDLE cycle after DONE
        @(negedge clk);
        din = 32'h0000F00D; dir = 1'b0; mode = 2'b00; amount = 5'd2; start = 1'b1;
        t1 = -1; t2 = -1; cyc = 0;
        for (int k = 0; k < 40 && t2 < 0; k++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (t1 < 0) t1 = cyc;
                else begin
                    t2 = cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b interval", 32'(t2 - t1), 32'd5);
        @(negedge clk);
        check("b2b result", result, 32'h0003C034);

        // asynchronous clear in the middle of a long shift
        @(negedge clk);
        din = 32'h13579BDF; dir = 1'b1; mode = 2'b00; amount = 5'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        clear = 1'b0;
        #1;
        check("clr busy", 32'(busy), 32'd0);
        check("clr s", 32'(s), 32'd0);
        check("clr result", result, 32'd0);
        check("clr done", 32'(done), 32'd0);
        check("clr pdata", pdata, 32'd0);
        @(negedge clk);
        clear = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("clr no_done", 32'(ndone), 32'd0);

`ifdef SHIFT_SEQ_ABORT_EN
        run_op("pre_abort", 32'h0F0F0F0F, 1'b0, 2'b10, 5'd4, 1'b0);
        prev = result;
        @(negedge clk);
        din = 32'hCAFEBABE; dir = 1'b1; mode = 2'b00; amount = 5'd8; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort s", 32'(s), 32'd0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no_done", 32'(ndone), 32'd0);
        check("abort result", result, prev);
`else
        prev = 32'd0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_32.md
# shift_seq_32

Sequencer that sits directly upstream of the 32-bit universal shift register built from four-bit 74LS194-style slices. It accepts a word, a direction, a shift mode and an amount, and drives the register's parallel data, mode select and serial inputs. It loads the word and issues exactly `amount` single-bit shifts. It reads the register's `Q` back for arithmetic/rotate fill and returns the final word with a one-cycle `done`.

## Interface
Parameters: none (width fixed at 32, amount fixed at 5 bits).

Ports:
- `clk` in 1: single clock, rising edge; the same clock drives the shift register.
- `clear` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `din` in 32: word to be shifted.
- `dir` in 1: 0 = left (toward bit 31), 1 = right (toward bit 0).
- `mode` in 2: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- `amount` in 5: shift count, 0..31.
- `q` in 32: feedback from the shift register `Q`.
- `pdata` out 32: to register `PData`.
- `s` out 2: to register `S`. 00 hold, 01 shift right (`Q[i]<=Q[i+1]`, `Q[31]<=SR`), 10 shift left (`Q[i]<=Q[i-1]`, `Q[0]<=SL`), 11 parallel load.
- `sr` out 1: serial-in at bit 31 for right shifts.
- `sl` out 1: serial-in at bit 0 for left shifts.
- `busy` out 1: high in LOAD, SHIFT, DONE.
- `done` out 1: one-cycle completion pulse.
- `result` out 32: final word, held until the next completion.

## Operation
- **States:** IDLE, LOAD, SHIFT, DONE, held in a registered state plus a 5-bit down-counter `cnt`.
- **IDLE**
  - `s=00`, `busy=0`.
  - On `start=1` at a clock edge, latch `din`, `dir`, `mode` and `amount` into internal registers and go to LOAD.
- **LOAD**
  - `s=11`, `pdata` = latched word.
  - If latched amount is 0, go to DONE. Otherwise set `cnt` = amount and go to SHIFT.
- **SHIFT**
  - `s=01` if dir=1, `s=10` if dir=0.
  - Right fill `sr`: logical 0; arithmetic `q[31]`; rotate `q[0]`.
  - Left fill `sl`: logical 0; arithmetic 0; rotate `q[31]`.
  - The unused serial input is driven 0.
  - `cnt` decrements each cycle. When `cnt==1`, go to DONE.
- **DONE**
  - `s=00`, `done=1`. `q` already holds the final word.
  - `result<=q` on the edge leaving DONE; next state IDLE.
- **Outputs outside active states:** `pdata` is driven with the latched word at all times and is only consumed when `s=11`. `sr`/`sl` are 0 outside SHIFT.
- **`start` while busy:** ignored. Not queued, no effect on latched operands.
- **Input changes:** changes to `din`/`mode`/`dir`/`amount` after acceptance have no effect.
- **Reset:**
  - `clear=0` at any time, including mid-SHIFT, forces IDLE with `cnt=0`, `s=00`, `sr=0`, `sl=0`, `busy=0`, `done=0`, `result=0`, `pdata=0` and latched operands 0.
  - The register holds whatever it had unless its own `clear` is also asserted; the bench ties both clears together.

## Timing
- Start accepted at edge E0.
  - LOAD is the cycle after E0.
  - SHIFT occupies cycles 2..amount+1.
  - `done` is high in cycle amount+2.
  - `result` is valid from the edge ending that cycle.
- Back-to-back: `start` held high is accepted again in the first IDLE cycle after DONE. The minimum issue interval is amount+3 cycles.
- `s`, `sr`, `sl` and `pdata` are registered-state-decoded with no combinational path from `start`. `sr`/`sl` in rotate/arithmetic mode are combinational from `q`.
- Reset values: every output is 0.

## Configuration
- `SHIFT_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort=1` in LOAD or SHIFT sends the block to IDLE on the next edge with `s=00`.
  - No `done`; `result` is unchanged and the register keeps its partial contents.
  - `abort` is ignored in IDLE and DONE.
- Macro undefined: no `abort` port; operations always run to completion.

## Test plan
Bench instantiates shift_seq_32 wired to the 32-bit 74LS194 register chain.
- Logical right: `din=0x80000001`, dir=1, mode=00, amount=4 -> `done` 6 cycles after acceptance; `result=0x08000000`.
- Arithmetic right: `din=0x80000000`, dir=1, mode=01, amount=3 -> `result=0xF0000000`. Arithmetic left on `0x40000001` by 1 -> `0x80000002`.
- Rotate: `din=0x80000001`, dir=0, mode=10, amount=1 -> `0x00000003`. Rotate right by 31 on `0x00000001` -> `0x00000002`.
- Amount 0: `din=0x12345678` -> `done` 2 cycles after acceptance; `result=0x12345678`, no `s=01`/`10` cycle observed.
- Busy/reset:
  - `start` pulsed in SHIFT with a different `din` -> ignored, original result produced.
  - `clear=0` mid-SHIFT -> next sample `busy=0`, `s=00`, `result=0`, no `done`.
- With `SHIFT_SEQ_ABORT_EN`: `abort` in second SHIFT cycle of an amount=8 op -> IDLE next edge, no `done`, `result` retains previous value.
